// File: rtl/axis_rr_arbiter_if.sv
// Stream bundle shared by NUM_IN sources, the round-robin arbiter and its single sink.
interface axis_rr_arbiter_if #(
    parameter int unsigned NUM_IN     = 4,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned ID_WIDTH = $clog2(NUM_IN);

    logic [NUM_IN*DATA_WIDTH-1:0] s_data;
    logic [NUM_IN-1:0]            s_valid;
    logic [NUM_IN-1:0]            s_last;
    logic [NUM_IN-1:0]            s_ready;
    logic [DATA_WIDTH-1:0]        m_data;
    logic                         m_last;
    logic [ID_WIDTH-1:0]          m_id;
    logic                         m_valid;
    logic                         m_ready;

    // Arbiter view
    modport slave (
        input  s_data, s_valid, s_last, m_ready,
        output s_ready, m_data, m_last, m_id, m_valid
    );

    // Environment view: the sources plus the downstream sink
    modport master (
        output s_data, s_valid, s_last, m_ready,
        input  s_ready, m_data, m_last, m_id, m_valid
    );
endinterface

// File: rtl/axis_rr_arbiter.sv
// Packet-aware round-robin arbiter: NUM_IN AXI-Stream sources onto one sink
// through a single registered output stage.
module axis_rr_arbiter #(
    parameter int unsigned NUM_IN     = 4,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic             aclk,
    input  logic             areset,
    axis_rr_arbiter_if.slave bus
);
    localparam int unsigned ID_WIDTH  = $clog2(NUM_IN);
    localparam int unsigned SUM_WIDTH = ID_WIDTH + 1;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t                state, state_nxt;
    logic [ID_WIDTH-1:0]   grant, grant_nxt;
    logic [ID_WIDTH-1:0]   last_grant, last_grant_nxt;
    logic [ID_WIDTH-1:0]   rr_pick;
    logic [SUM_WIDTH-1:0]  rr_idx;
    logic                  rr_found;
    logic                  out_ready_c;
    logic                  accept_c;
    logic [DATA_WIDTH-1:0] src_data [NUM_IN];

    for (genvar i = 0; i < NUM_IN; i++) begin : g_src
        assign src_data[i] = bus.s_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    assign out_ready_c = !bus.m_valid || bus.m_ready;

    // First requester after last_grant, wrapping modulo NUM_IN
    always_comb begin
        rr_pick  = '0;
        rr_idx   = '0;
        rr_found = 1'b0;
        for (int unsigned i = 1; i <= NUM_IN; i++) begin
            rr_idx = {1'b0, last_grant} + SUM_WIDTH'(i);
            if (rr_idx >= SUM_WIDTH'(NUM_IN)) begin
                rr_idx = rr_idx - SUM_WIDTH'(NUM_IN);
            end
            if (!rr_found && bus.s_valid[rr_idx[ID_WIDTH-1:0]]) begin
                rr_pick  = rr_idx[ID_WIDTH-1:0];
                rr_found = 1'b1;
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= ID_WIDTH'(NUM_IN - 1);
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    // Grant is held until the beat carrying s_last is accepted
    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;
        bus.s_ready    = '0;
        accept_c       = 1'b0;
        case (state)
            IDLE: begin
                if (|bus.s_valid) begin
                    grant_nxt = rr_pick;
                    state_nxt = LOCKED;
                end
            end
            LOCKED: begin
                bus.s_ready[grant] = out_ready_c;
                accept_c           = bus.s_valid[grant] && out_ready_c;
                if (accept_c && bus.s_last[grant]) begin
                    state_nxt      = IDLE;
                    last_grant_nxt = grant;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // One-deep output register; payload frozen while stalled
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            bus.m_valid <= 1'b0;
            bus.m_data  <= '0;
            bus.m_last  <= 1'b0;
            bus.m_id    <= '0;
        end else if (accept_c) begin
            bus.m_valid <= 1'b1;
            bus.m_data  <= src_data[grant];
            bus.m_last  <= bus.s_last[grant];
            bus.m_id    <= grant;
        end else if (bus.m_ready) begin
            bus.m_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed bench for axis_rr_arbiter: reset, single packet, round robin,
// back-pressure, lock hold and single-beat packets.
module tb_axis_rr_arbiter;
    localparam int unsigned NUM_IN     = 4;
    localparam int unsigned DATA_WIDTH = 32;

    logic                  aclk = 1'b0;
    logic                  areset;
    logic [NUM_IN-1:0]     s_valid;
    logic [NUM_IN-1:0]     s_last;
    logic [DATA_WIDTH-1:0] src_d [NUM_IN];
    logic                  m_ready;

    int tests_run    = 0;
    int tests_failed = 0;

    // Source model state for the handshake-driven scenarios
    int                    pkt      [NUM_IN];
    int                    beat     [NUM_IN];
    int                    pkt_len  [NUM_IN];
    int                    max_pkts [NUM_IN];
    logic [DATA_WIDTH-1:0] base     [NUM_IN];
    logic [NUM_IN-1:0]     last_fire;
    logic [DATA_WIDTH-1:0] q_data [$];
    logic [1:0]            q_id   [$];
    logic                  q_last [$];

    axis_rr_arbiter_if #(.NUM_IN(NUM_IN), .DATA_WIDTH(DATA_WIDTH)) bus ();

    assign bus.s_valid = s_valid;
    assign bus.s_last  = s_last;
    assign bus.s_data  = {src_d[3], src_d[2], src_d[1], src_d[0]};
    assign bus.m_ready = m_ready;

    axis_rr_arbiter #(.NUM_IN(NUM_IN), .DATA_WIDTH(DATA_WIDTH)) dut (
        .aclk   (aclk),
        .areset (areset),
        .bus    (bus.slave)
    );

    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic apply_reset();
        areset  = 1'b1;
        s_valid = '0;
        s_last  = '0;
        m_ready = 1'b1;
        for (int i = 0; i < NUM_IN; i++) begin
            src_d[i] = '0; pkt[i] = 0; beat[i] = 0;
            pkt_len[i] = 1; max_pkts[i] = 0; base[i] = '0;
        end
        q_data.delete(); q_id.delete(); q_last.delete();
        repeat (2) @(posedge aclk);
        #1;
        areset = 1'b0;
    endtask

    task automatic src_refresh();
        for (int i = 0; i < NUM_IN; i++) begin
            s_valid[i] = (pkt[i] < max_pkts[i]);
            s_last[i]  = (beat[i] == pkt_len[i] - 1);
            src_d[i]   = base[i] + 32'(pkt[i] * 16) + 32'(beat[i]);
        end
    endtask

    // One clock: sample handshakes mid-cycle, advance sources after the edge
    task automatic src_cycle();
        @(negedge aclk);
        last_fire = s_valid & bus.s_ready;
        if (bus.m_valid && bus.m_ready) begin
            q_data.push_back(bus.m_data);
            q_id.push_back(bus.m_id);
            q_last.push_back(bus.m_last);
        end
        @(posedge aclk);
        #1;
        for (int i = 0; i < NUM_IN; i++) begin
            if (last_fire[i]) begin
                if (beat[i] == pkt_len[i] - 1) begin
                    beat[i] = 0;
                    pkt[i]  = pkt[i] + 1;
                end else begin
                    beat[i] = beat[i] + 1;
                end
            end
        end
        src_refresh();
    endtask

    task automatic test_reset();
        areset = 1'b1; s_valid = '0; s_last = '0; m_ready = 1'b1;
        for (int i = 0; i < NUM_IN; i++) src_d[i] = '0;
        #1;
        tests_run++; if (bus.m_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_m_valid: got %b expected 0", bus.m_valid); end
        tests_run++; if (bus.s_ready !== 4'b0000) begin tests_failed++; $display("FAIL reset_s_ready: got %b expected 0000", bus.s_ready); end
        @(posedge aclk); #1;
        areset = 1'b0;
        src_d[1] = 32'hCAFE_0001; s_valid = 4'b0010; m_ready = 1'b0;
        tick();
        tests_run++; if (bus.s_ready !== 4'b0010) begin tests_failed++; $display("FAIL reset_pre_ready: got %b expected 0010", bus.s_ready); end
        tick();
        tests_run++; if (bus.m_valid !== 1'b1 || bus.m_id !== 2'd1 || bus.m_data !== 32'hCAFE_0001) begin tests_failed++; $display("FAIL reset_pre_beat: got v=%b id=%0d d=%h expected v=1 id=1 d=cafe0001", bus.m_valid, bus.m_id, bus.m_data); end
        #3;
        m_ready = 1'b1;
        #1;
        areset = 1'b1;
        #1;
        tests_run++; if (bus.m_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_async_valid: got %b expected 0", bus.m_valid); end
        tests_run++; if (bus.m_data !== 32'h0 || bus.m_id !== 2'd0 || bus.m_last !== 1'b0) begin tests_failed++; $display("FAIL reset_async_payload: got d=%h id=%0d l=%b expected 0/0/0", bus.m_data, bus.m_id, bus.m_last); end
        tests_run++; if (bus.s_ready !== 4'b0000) begin tests_failed++; $display("FAIL reset_async_ready: got %b expected 0000", bus.s_ready); end
        s_valid = '0;
        @(posedge aclk); #1;
        areset = 1'b0;
    endtask

    task automatic test_single_source();
        apply_reset();
        src_d[2] = 32'hA0; s_valid = 4'b0100; s_last = 4'b0000;
        tick();
        tests_run++; if (bus.s_ready !== 4'b0100 || bus.m_valid !== 1'b0) begin tests_failed++; $display("FAIL single_arb: got rdy=%b v=%b expected 0100/0", bus.s_ready, bus.m_valid); end
        tick();
        tests_run++; if (bus.m_valid !== 1'b1 || bus.m_data !== 32'hA0 || bus.m_id !== 2'd2 || bus.m_last !== 1'b0) begin tests_failed++; $display("FAIL single_beat0: got v=%b d=%h id=%0d l=%b expected 1/a0/2/0", bus.m_valid, bus.m_data, bus.m_id, bus.m_last); end
        src_d[2] = 32'hA1;
        tick();
        tests_run++; if (bus.m_valid !== 1'b1 || bus.m_data !== 32'hA1 || bus.m_last !== 1'b0) begin tests_failed++; $display("FAIL single_beat1: got v=%b d=%h l=%b expected 1/a1/0", bus.m_valid, bus.m_data, bus.m_last); end
        src_d[2] = 32'hA2; s_last = 4'b0100;
        tick();
        tests_run++; if (bus.m_valid !== 1'b1 || bus.m_data !== 32'hA2 || bus.m_id !== 2'd2 || bus.m_last !== 1'b1) begin tests_failed++; $display("FAIL single_beat2: got v=%b d=%h id=%0d l=%b expected 1/a2/2/1", bus.m_valid, bus.m_data, bus.m_id, bus.m_last); end
        s_valid = '0; s_last = '0;
        tick();
        tests_run++; if (bus.m_valid !== 1'b0 || bus.s_ready !== 4'b0000) begin tests_failed++; $display("FAIL single_drain: got v=%b rdy=%b expected 0/0000", bus.m_valid, bus.s_ready); end
    endtask

    task automatic test_round_robin();
        int n;
        int exp_id;
        logic [31:0] exp_d;
        apply_reset();
        for (int i = 0; i < NUM_IN; i++) begin
            base[i] = 32'(i) << 8; pkt_len[i] = 2; max_pkts[i] = 1000;
        end
        src_refresh();
        n = 0;
        while (q_id.size() < 10 && n < 80) begin
            src_cycle();
            n++;
        end
        tests_run++; if (q_id.size() < 10) begin tests_failed++; $display("FAIL rr_count: got %0d beats expected 10", q_id.size()); end
        for (int k = 0; k < 10 && k < q_id.size(); k++) begin
            exp_id = (k / 2) % 4;
            exp_d  = 32'((exp_id << 8) | ((k / 8) << 4) | (k % 2));
            tests_run++;
            if (q_id[k] !== 2'(exp_id) || q_data[k] !== exp_d || q_last[k] !== 1'(k % 2)) begin
                tests_failed++;
                $display("FAIL rr_beat%0d: got id=%0d d=%h l=%b expected id=%0d d=%h l=%0d", k, q_id[k], q_data[k], q_last[k], exp_id, exp_d, k % 2);
            end
        end
    endtask

    task automatic test_back_pressure();
        int n;
        int accepted;
        apply_reset();
        base[1] = 32'h10; pkt_len[1] = 4; max_pkts[1] = 1;
        src_refresh();
        n = 0; accepted = 0;
        while (bus.m_valid !== 1'b1 && n < 20) begin
            src_cycle();
            accepted += $countones(last_fire);
            n++;
        end
        tests_run++; if (bus.m_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_first: got m_valid=%b expected 1", bus.m_valid); end
        m_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            src_cycle();
            accepted += $countones(last_fire);
            tests_run++; if (bus.m_valid !== 1'b1 || bus.m_data !== 32'h10) begin tests_failed++; $display("FAIL bp_hold%0d: got v=%b d=%h expected 1/10", k, bus.m_valid, bus.m_data); end
        end
        tests_run++; if (accepted !== 1) begin tests_failed++; $display("FAIL bp_accepted: got %0d expected 1", accepted); end
        m_ready = 1'b1;
        n = 0;
        while (q_data.size() < 4 && n < 30) begin
            src_cycle();
            n++;
        end
        repeat (3) src_cycle();
        tests_run++; if (q_data.size() !== 4) begin tests_failed++; $display("FAIL bp_count: got %0d beats expected 4", q_data.size()); end
        for (int k = 0; k < 4 && k < q_data.size(); k++) begin
            tests_run++;
            if (q_data[k] !== 32'h10 + 32'(k) || q_id[k] !== 2'd1 || q_last[k] !== (k == 3)) begin
                tests_failed++;
                $display("FAIL bp_beat%0d: got d=%h id=%0d l=%b expected d=%h id=1 l=%0d", k, q_data[k], q_id[k], q_last[k], 32'h10 + 32'(k), (k == 3));
            end
        end
    endtask

    task automatic test_lock_hold();
        apply_reset();
        src_d[0] = 32'h30; src_d[3] = 32'h70; s_valid = 4'b1001; s_last = 4'b1000;
        tick();
        tests_run++; if (bus.s_ready !== 4'b0001) begin tests_failed++; $display("FAIL lock_grant0: got %b expected 0001", bus.s_ready); end
        tick();
        tests_run++; if (bus.m_data !== 32'h30 || bus.m_id !== 2'd0 || bus.m_valid !== 1'b1) begin tests_failed++; $display("FAIL lock_beat0: got d=%h id=%0d v=%b expected 30/0/1", bus.m_data, bus.m_id, bus.m_valid); end
        s_valid = 4'b1000; src_d[0] = 32'h31;
        for (int k = 0; k < 3; k++) begin
            tests_run++; if (bus.s_ready !== 4'b0001) begin tests_failed++; $display("FAIL lock_gap%0d: got %b expected 0001", k, bus.s_ready); end
            tick();
        end
        s_valid = 4'b1001; s_last = 4'b1001;
        tests_run++; if (bus.s_ready !== 4'b0001) begin tests_failed++; $display("FAIL lock_resume: got %b expected 0001", bus.s_ready); end
        tick();
        tests_run++; if (bus.m_data !== 32'h31 || bus.m_id !== 2'd0 || bus.m_last !== 1'b1) begin tests_failed++; $display("FAIL lock_beat1: got d=%h id=%0d l=%b expected 31/0/1", bus.m_data, bus.m_id, bus.m_last); end
        s_valid = 4'b1000;
        tests_run++; if (bus.s_ready !== 4'b0000) begin tests_failed++; $display("FAIL lock_idle: got %b expected 0000", bus.s_ready); end
        tick();
        tests_run++; if (bus.s_ready !== 4'b1000) begin tests_failed++; $display("FAIL lock_grant3: got %b expected 1000", bus.s_ready); end
        tick();
        s_valid = '0;
        tests_run++; if (bus.m_data !== 32'h70 || bus.m_id !== 2'd3 || bus.m_last !== 1'b1 || bus.m_valid !== 1'b1) begin tests_failed++; $display("FAIL lock_beat3: got d=%h id=%0d l=%b v=%b expected 70/3/1/1", bus.m_data, bus.m_id, bus.m_last, bus.m_valid); end
    endtask

    task automatic test_single_beat();
        apply_reset();
        src_d[1] = 32'h55; src_d[3] = 32'h66; s_valid = 4'b1010; s_last = 4'b1010;
        tick();
        tests_run++; if (bus.s_ready !== 4'b0010) begin tests_failed++; $display("FAIL sb_grant1: got %b expected 0010", bus.s_ready); end
        tick();
        s_valid = 4'b1000;
        tests_run++; if (bus.m_valid !== 1'b1 || bus.m_data !== 32'h55 || bus.m_id !== 2'd1 || bus.m_last !== 1'b1) begin tests_failed++; $display("FAIL sb_out1: got v=%b d=%h id=%0d l=%b expected 1/55/1/1", bus.m_valid, bus.m_data, bus.m_id, bus.m_last); end
        tests_run++; if (bus.s_ready !== 4'b0000) begin tests_failed++; $display("FAIL sb_gap: got %b expected 0000", bus.s_ready); end
        tick();
        tests_run++; if (bus.s_ready !== 4'b1000 || bus.m_valid !== 1'b0) begin tests_failed++; $display("FAIL sb_grant3: got rdy=%b v=%b expected 1000/0", bus.s_ready, bus.m_valid); end
        tick();
        s_valid = '0;
        tests_run++; if (bus.m_valid !== 1'b1 || bus.m_data !== 32'h66 || bus.m_id !== 2'd3 || bus.m_last !== 1'b1) begin tests_failed++; $display("FAIL sb_out3: got v=%b d=%h id=%0d l=%b expected 1/66/3/1", bus.m_valid, bus.m_data, bus.m_id, bus.m_last); end
        tick();
        tests_run++; if (bus.m_valid !== 1'b0) begin tests_failed++; $display("FAIL sb_drain: got %b expected 0", bus.m_valid); end
    endtask

    initial begin
        test_reset();
        test_single_source();
        test_round_robin();
        test_back_pressure();
        test_lock_hold();
        test_single_beat();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/axis_rr_arbiter.md
# axis_rr_arbiter

Round-robin, packet-aware arbiter that shares one AXI-Stream sink, typically the slave side of the team's stream FIFO, between NUM_IN independent stream sources. A source holds the grant from its first beat through the beat carrying s_last, so packets are never interleaved. The output is registered, one beat deep, with full valid/ready back-pressure.

## Interface
- NUM_IN, 4: number of requesting sources, 2..16.
- DATA_WIDTH, 32: payload width per beat.
- ID_WIDTH, derived: $clog2(NUM_IN); not overridable.
- aclk  in  1  clock; all logic is on its rising edge.
- areset  in  1  reset, asynchronous, active-high.
- s_data  in  NUM_IN*DATA_WIDTH  source payloads; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- s_valid  in  NUM_IN  per-source valid.
- s_last  in  NUM_IN  per-source end-of-packet marker.
- s_ready  out  NUM_IN  per-source ready; at most one bit is high at a time.
- m_data  out  DATA_WIDTH  registered output payload.
- m_last  out  1  registered end-of-packet marker.
- m_id  out  ID_WIDTH  index of the source that produced the current m_data.
- m_valid  out  1  output valid.
- m_ready  in  1  downstream ready (FIFO s_ready).

## Operation
- Two states: IDLE and LOCKED. Registers are state, grant[ID_WIDTH], last_grant[ID_WIDTH], and the output register (m_data, m_last, m_id, m_valid).
- out_ready = !m_valid || m_ready (the output register can accept a beat this cycle).
- IDLE:
  - All s_ready are 0.
  - If any s_valid is set, grant <= first index with s_valid set, searching last_grant+1, last_grant+2, … modulo NUM_IN. State <= LOCKED.
  - If no s_valid is set, stay in IDLE.
- LOCKED:
  - s_ready[grant] = out_ready. All other s_ready are 0.
  - A beat is accepted when s_valid[grant] && s_ready[grant].
  - On an accepted beat: m_data <= that source's data, m_last <= s_last[grant], m_id <= grant, m_valid <= 1.
  - If the accepted beat has s_last = 1: state <= IDLE and last_grant <= grant.
  - A deasserted s_valid[grant] mid-packet keeps the lock. There is no timeout.
- Output register:
  - If m_valid && m_ready and no beat is accepted in the same cycle, m_valid <= 0.
  - If a beat is accepted, m_valid stays 1 and the data is replaced, whether or not m_ready is high.
  - While m_valid && !m_ready, m_data, m_last and m_id are held stable.
- Round-robin order: a source that has just finished a packet has the lowest priority at the next arbitration. Every requester is served within NUM_IN packets.
- Single-beat packets (s_last on the first beat) are legal. Such a packet takes one LOCKED cycle when out_ready is high.
- Reset (asynchronous, takes effect immediately regardless of clock):
  - state = IDLE, grant = 0, last_grant = NUM_IN-1 (so source 0 wins first).
  - m_valid = 0, m_data = 0, m_last = 0, m_id = 0, all s_ready = 0.
  - A packet in flight at reset is truncated. No recovery beat is generated.

## Timing
- Arbitration costs one cycle. If s_valid[i] rises at edge 0 in IDLE, s_ready[i] is high during cycle 1, and with m_ready = 1 the first beat appears on m_valid/m_data after edge 2.
- Latency from source acceptance to the output is exactly one cycle.
- Within a packet, throughput is 1 beat/cycle while m_ready = 1.
- Between consecutive packets there is exactly one idle input cycle (the IDLE arbitration cycle). The output stays continuous only if downstream stalls absorb that gap.
- s_ready depends combinationally on m_ready through out_ready. There is no combinational path from s_valid to s_ready.
- m_valid, m_data, m_last and m_id come directly from registers.

## Test plan
- Reset check: assert areset mid-cycle with any stimulus -> m_valid = 0, m_data = 0, m_id = 0 and s_ready = 0 immediately, before the next clock edge.
- Single source, m_ready = 1: source 2 sends a 3-beat packet 0xA0, 0xA1, 0xA2 (last on 0xA2) -> m_data shows 0xA0..0xA2 on three consecutive cycles, m_id = 2, m_last only on 0xA2, first beat at cycle 2.
- Round robin: all 4 sources continuously offer 2-beat packets -> output m_id sequence is 0,0,1,1,2,2,3,3,0,0, with no interleaving within a packet.
- Back-pressure: hold m_ready = 0 for 5 cycles mid-packet from source 1 (beats 0x10..0x13) -> m_data is held stable, only one beat is accepted until m_ready returns, and all four beats arrive in order with none lost or duplicated.
- Lock hold: source 0 drops s_valid for 3 cycles between beats while source 3 is requesting -> source 3's s_ready stays 0 until source 0's last beat is accepted; source 3 is granted next.
- Single-beat packets from sources 1 and 3 (data 0x55 and 0x66, last = 1) -> output is 0x55 with m_id = 1, then 0x66 with m_id = 3, each with m_last = 1, separated by one arbitration cycle on the input side.
